// File: rtl/aes_pkg.sv
// Shared definitions for the (Inv)ShiftRows datapath: byte addressing,
// per-row rotation amounts and the direction enum.
package aes_pkg;

  localparam int NB_MAX = 8;

  typedef enum logic {
    RD_FWD = 1'b0,
    RD_INV = 1'b1
  } rd_mode_e;

  // MSB position of byte s[r][c] in a 32*nb-bit state vector (column-major, s[0][0] on top).
  function automatic int byte_idx(input int r, input int c, input int nb);
    return 32 * nb - 1 - 8 * (4 * c + r);
  endfunction

  function automatic int shift_off(input int r, input int nb);
    return (nb == 8 && r >= 2) ? r + 1 : r;
  endfunction

endpackage

// File: rtl/shiftrows_pipe_if.sv
// One valid/ready beat channel carrying a state, its direction flag and a sideband tag.
// A beat transfers on a rising edge where valid & ready; master holds fields stable while valid & !ready.
interface shiftrows_pipe_if #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
);
  logic              valid;
  logic              ready;
  logic [32*NB-1:0]  data;
  logic              inv;
  logic [TAG_W-1:0]  tag;

  modport master (output valid, data, inv, tag, input ready);
  modport slave  (input valid, data, inv, tag, output ready);
endinterface

// File: rtl/shiftrows_pipe_perm.sv
// Combinational ShiftRows / InvShiftRows byte routing for an NB-column state.
// Pure wiring: every output byte selects one input byte of the same row.
module shiftrows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] in_data,
  input  rd_mode_e         mode,
  output logic [32*NB-1:0] out_data
);

  function automatic int src_col(input int r, input int c, input rd_mode_e m);
    int sh;
    sh = shift_off(r, NB);
    return (m == RD_INV) ? (c + NB - sh) % NB : (c + sh) % NB;
  endfunction

  always_comb begin
    out_data = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NB; c++) begin
        out_data[byte_idx(r, c, NB) -: 8] = in_data[byte_idx(r, src_col(r, c, mode), NB) -: 8];
      end
    end
  end

endmodule

// File: rtl/shiftrows_pipe.sv
// Registered (Inv)ShiftRows stage with valid/ready handshake and sideband tag.
// Define SHIFTROWS_SKID_EN to add a 1-entry skid buffer and register in_ready.
module shiftrows_pipe
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  shiftrows_pipe_if.slave   in_if,
  shiftrows_pipe_if.master  out_if
);

  if (!(NB == 4 || NB == 6 || NB == 8) || NB > NB_MAX) begin : g_bad_nb
    $error("shiftrows_pipe: NB must be 4, 6 or 8");
  end
  if (TAG_W < 1 || TAG_W > 16) begin : g_bad_tag
    $error("shiftrows_pipe: TAG_W must be in 1..16");
  end

  logic [32*NB-1:0] perm_data;
  rd_mode_e         in_mode;
  logic             in_ready;
  logic             accept;
  logic             out_free;

  logic              out_valid_q;
  logic [32*NB-1:0]  out_data_q;
  logic              out_inv_q;
  logic [TAG_W-1:0]  out_tag_q;

  assign in_mode = in_if.inv ? RD_INV : RD_FWD;

  shiftrows_perm #(.NB(NB)) u_perm (
    .in_data  (in_if.data),
    .mode     (in_mode),
    .out_data (perm_data)
  );

  assign out_free = !out_valid_q || out_if.ready;
  // Gated by valid so idle-cycle garbage on in_data never reaches the registers.
  assign accept   = in_if.valid && in_ready;

`ifdef SHIFTROWS_SKID_EN
  logic              skid_valid_q;
  logic [32*NB-1:0]  skid_data_q;
  logic              skid_inv_q;
  logic [TAG_W-1:0]  skid_tag_q;

  // Registered ready: a beat arriving during a stall lands in the skid entry.
  assign in_ready = !skid_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q  <= accept;
      end
    end else if (accept) begin
      skid_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_inv_q   <= 1'b0;
      out_tag_q   <= '0;
      skid_data_q <= '0;
      skid_inv_q  <= 1'b0;
      skid_tag_q  <= '0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_data_q <= skid_data_q;
        out_inv_q  <= skid_inv_q;
        out_tag_q  <= skid_tag_q;
      end else if (accept) begin
        out_data_q <= perm_data;
        out_inv_q  <= in_if.inv;
        out_tag_q  <= in_if.tag;
      end
    end else if (accept) begin
      skid_data_q <= perm_data;
      skid_inv_q  <= in_if.inv;
      skid_tag_q  <= in_if.tag;
    end
  end
`else
  assign in_ready = !flush && out_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (out_free) begin
      out_valid_q <= accept;
    end
  end

  // Data registers are deliberately untouched by flush; only valid is cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_inv_q  <= 1'b0;
      out_tag_q  <= '0;
    end else if (accept) begin
      out_data_q <= perm_data;
      out_inv_q  <= in_if.inv;
      out_tag_q  <= in_if.tag;
    end
  end
`endif

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid_q;
  assign out_if.data  = out_data_q;
  assign out_if.inv   = out_inv_q;
  assign out_if.tag   = out_tag_q;

endmodule

// File: tb/tb_shiftrows_pipe.sv
// Directed bench for shiftrows_pipe: NB=4 handshake/flush/reset scenarios plus
// NB=6 and NB=8 permutation and round-trip checks, scored through expected queues.
module tb_shiftrows_pipe;

  localparam logic [127:0] V1 = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] V2 = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [191:0] IDX6 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [191:0] FWD6 = 192'h00050a0f04090e13080d12170c11160310150207_1401060b;
  localparam logic [255:0] IDX8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] FWD8 = 256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;

  logic clk;
  logic rst_n;
  logic flush;
  logic no_flush;

  int tests_run;
  int tests_failed;

  logic [263:0] q4[$];
  logic [263:0] q6[$];
  logic [263:0] q8[$];

  shiftrows_pipe_if #(.NB(4), .TAG_W(4)) a_if ();
  shiftrows_pipe_if #(.NB(4), .TAG_W(4)) b_if ();
  shiftrows_pipe_if #(.NB(6), .TAG_W(4)) c6_in ();
  shiftrows_pipe_if #(.NB(6), .TAG_W(4)) c6_out ();
  shiftrows_pipe_if #(.NB(8), .TAG_W(4)) c8_in ();
  shiftrows_pipe_if #(.NB(8), .TAG_W(4)) c8_out ();

  shiftrows_pipe #(.NB(4), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_if(a_if), .out_if(b_if)
  );
  shiftrows_pipe #(.NB(6), .TAG_W(4)) dut6 (
    .clk(clk), .rst_n(rst_n), .flush(no_flush), .in_if(c6_in), .out_if(c6_out)
  );
  shiftrows_pipe #(.NB(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(no_flush), .in_if(c8_in), .out_if(c8_out)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [263:0] act, input logic [263:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] ref_perm(input int nb, input logic [255:0] d, input logic inv);
    logic [255:0] res;
    int sh, src;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < nb; c++) begin
        sh  = (nb == 8 && r >= 2) ? r + 1 : r;
        src = inv ? (c + nb - sh) % nb : (c + sh) % nb;
        res[32*nb-1-8*(4*c+r) -: 8] = d[32*nb-1-8*(4*src+r) -: 8];
      end
    end
    return res;
  endfunction

  task automatic send4(input logic [127:0] d, input logic inv, input logic [3:0] tag,
                       input logic [127:0] e);
    int n;
    n = 0;
    @(negedge clk);
    a_if.valid = 1'b1; a_if.data = d; a_if.inv = inv; a_if.tag = tag;
    #1;
    while (!a_if.ready && n < 100) begin @(negedge clk); #1; n++; end
    if (!a_if.ready) begin
      tests_run++; tests_failed++;
      $display("FAIL send4_timeout: in_ready stayed %b, needed 1", a_if.ready);
    end else begin
      q4.push_back({inv, tag, d});
      q4[$] = {inv, tag, e};
      @(posedge clk);
    end
    #1;
    a_if.valid = 1'b0; a_if.data = 'x;
  endtask

  task automatic send_w(input int nb, input logic [255:0] d, input logic inv,
                        input logic [3:0] tag, input logic [255:0] e);
    int n;
    logic rdy;
    n = 0;
    @(negedge clk);
    if (nb == 6) begin
      c6_in.valid = 1'b1; c6_in.data = d[191:0]; c6_in.inv = inv; c6_in.tag = tag;
    end else begin
      c8_in.valid = 1'b1; c8_in.data = d; c8_in.inv = inv; c8_in.tag = tag;
    end
    #1;
    rdy = (nb == 6) ? c6_in.ready : c8_in.ready;
    while (!rdy && n < 100) begin
      @(negedge clk); #1; n++;
      rdy = (nb == 6) ? c6_in.ready : c8_in.ready;
    end
    if (!rdy) begin
      tests_run++; tests_failed++;
      $display("FAIL send_w_timeout: nb=%0d in_ready stayed 0, needed 1", nb);
    end else begin
      if (nb == 6) q6.push_back({inv, tag, e[191:0]});
      else         q8.push_back({inv, tag, e});
      @(posedge clk);
    end
    #1;
    c6_in.valid = 1'b0; c8_in.valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q4.size() + q6.size() + q8.size()) != 0 && n < 60) begin @(negedge clk); n++; end
    tests_run++;
    if ((q4.size() + q6.size() + q8.size()) != 0) begin
      tests_failed++;
      $display("FAIL %s_drain: %0d beats still pending, needed 0", name,
               q4.size() + q6.size() + q8.size());
    end
    @(negedge clk);
  endtask

  // ---------------- scoreboards / monitors ----------------
  initial begin
    logic [263:0] e;
    forever begin
      @(negedge clk); #2;
      if (rst_n && b_if.valid && b_if.ready) begin
        if (q4.size() == 0) check("nb4_unexpected_beat", {b_if.inv, b_if.tag, b_if.data}, '0);
        else begin
          e = q4.pop_front();
          check("nb4_beat", {b_if.inv, b_if.tag, b_if.data}, e);
        end
      end
    end
  end

  initial begin
    logic [263:0] e;
    forever begin
      @(negedge clk); #2;
      if (rst_n && c6_out.valid && c6_out.ready) begin
        if (q6.size() == 0) check("nb6_unexpected_beat", {c6_out.inv, c6_out.tag, c6_out.data}, '0);
        else begin
          e = q6.pop_front();
          check("nb6_beat", {c6_out.inv, c6_out.tag, c6_out.data}, e);
        end
      end
    end
  end

  initial begin
    logic [263:0] e;
    forever begin
      @(negedge clk); #2;
      if (rst_n && c8_out.valid && c8_out.ready) begin
        if (q8.size() == 0) check("nb8_unexpected_beat", {c8_out.inv, c8_out.tag, c8_out.data}, '0);
        else begin
          e = q8.pop_front();
          check("nb8_beat", {c8_out.inv, c8_out.tag, c8_out.data}, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    tests_failed++;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int n;
    logic [255:0] x, y;
    tests_run = 0; tests_failed = 0;
    rst_n = 1'b0; flush = 1'b0; no_flush = 1'b0;
    a_if.valid = 1'b0; a_if.data = '0; a_if.inv = 1'b0; a_if.tag = '0; b_if.ready = 1'b1;
    c6_in.valid = 1'b0; c6_in.data = '0; c6_in.inv = 1'b0; c6_in.tag = '0; c6_out.ready = 1'b1;
    c8_in.valid = 1'b0; c8_in.data = '0; c8_in.inv = 1'b0; c8_in.tag = '0; c8_out.ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", b_if.valid, 1'b0);
    check("rst_out_fields", {b_if.inv, b_if.tag, b_if.data}, '0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("post_rst_in_ready", a_if.ready, 1'b1);

    // Vectors 1 and 2, with 1-clk latency check
    send4(V1, 1'b0, 4'h5, V2);
    check("lat_fwd_out_valid", b_if.valid, 1'b1);
    send4(V2, 1'b1, 4'ha, V1);
    check("lat_inv_out_valid", b_if.valid, 1'b1);
    drain("vec12");

    // 8 back-to-back beats, 8 consecutive out_valid cycles
    fork
      for (int i = 0; i < 8; i++) begin
        if (i % 2 == 0) send4(V1, 1'b0, 4'(i), V2);
        else            send4(V2, 1'b1, 4'(i), V1);
      end
      begin
        n = 0;
        @(negedge clk); #2;
        while (!b_if.valid && n < 20) begin @(negedge clk); #2; n++; end
        for (int k = 0; k < 8; k++) begin
          check("b2b_out_valid", b_if.valid, 1'b1);
          @(negedge clk); #2;
        end
        check("b2b_valid_after", b_if.valid, 1'b0);
      end
    join
    drain("b2b");

    // Stall for 5 clks: output stable, in_ready behaviour
    @(negedge clk);
    b_if.ready = 1'b0;
    send4(V1, 1'b0, 4'h9, V2);
    acc = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a_if.valid = 1'b1; a_if.data = V2; a_if.inv = 1'b1; a_if.tag = 4'hc;
      #1;
      if (a_if.ready) begin
        if (acc == 0) q4.push_back({1'b1, 4'hc, V1});
        acc++;
      end
`ifndef SHIFTROWS_SKID_EN
      check("stall_in_ready", a_if.ready, 1'b0);
`endif
      check("stall_out_stable", {b_if.valid, b_if.inv, b_if.tag, b_if.data}, {1'b1, 1'b0, 4'h9, V2});
    end
    @(negedge clk);
    a_if.valid = 1'b0;
`ifdef SHIFTROWS_SKID_EN
    check("stall_extra_accepts", acc, 1);
`else
    check("stall_extra_accepts", acc, 0);
`endif
    b_if.ready = 1'b1;
    drain("stall");

    // Flush with a beat in the output and one offered on the input
    b_if.ready = 1'b0;
    send4(V2, 1'b1, 4'h3, V1);
    @(negedge clk);
    a_if.valid = 1'b1; a_if.data = V1; a_if.inv = 1'b0; a_if.tag = 4'h7;
    flush = 1'b1;
    #1;
`ifndef SHIFTROWS_SKID_EN
    check("flush_in_ready", a_if.ready, 1'b0);
`endif
    @(posedge clk); #1;
    flush = 1'b0; a_if.valid = 1'b0;
    check("flush_out_valid", b_if.valid, 1'b0);
    q4.delete();
    b_if.ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #2;
      check("flush_no_ghost", b_if.valid, 1'b0);
    end
    send4(V1, 1'b0, 4'he, V2);
    drain("post_flush");

    // Asynchronous reset mid-stall
    b_if.ready = 1'b0;
    send4(V1, 1'b0, 4'h2, V2);
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", b_if.valid, 1'b0);
    check("async_rst_out_fields", {b_if.inv, b_if.tag, b_if.data}, '0);
    q4.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", a_if.ready, 1'b1);
    check("rel_out_valid", b_if.valid, 1'b0);
    b_if.ready = 1'b1;
    send4(V2, 1'b1, 4'h4, V1);
    drain("post_rst");

    // NB=6 / NB=8 byte-index vectors and round trips
    send_w(6, {64'h0, IDX6}, 1'b0, 4'h1, {64'h0, FWD6});
    send_w(6, {64'h0, FWD6}, 1'b1, 4'h2, {64'h0, IDX6});
    send_w(8, IDX8, 1'b0, 4'h3, FWD8);
    send_w(8, FWD8, 1'b1, 4'h4, IDX8);
    drain("idx");
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (i % 2 == 0) begin
        x[255:192] = '0;
        y = ref_perm(6, x, 1'b0);
        send_w(6, x, 1'b0, 4'(i), y);
        send_w(6, y, 1'b1, 4'(i + 1), x);
      end else begin
        y = ref_perm(8, x, 1'b0);
        send_w(8, x, 1'b0, 4'(i), y);
        send_w(8, y, 1'b1, 4'(i + 1), x);
      end
    end
    drain("random");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
